alu_mc: RTL
===========

Name: alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle datapath ALU, generalised in width and extended with shifts, iterative multiply and full NZCV flags.
- Operations issue through a start/busy/done handshake, so the processor stalls only for long operations.
- The block sits in the execute stage.
- Results and flags are registered and held until the next completion.

Parameters:
N, 64, operand/result width in bits (N >= 4, power of two)
SHAMT_W, $clog2(N), width of shift amount taken from b

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request to issue an operation; sampled at rising edge
a  in  N  operand A
b  in  N  operand B (shift amount in b[SHAMT_W-1:0])
ALUControl  in  4  operation select
busy  out  1  multi-cycle operation in progress
done  out  1  one-cycle pulse: result/flags just updated
result  out  N  registered result
zero  out  1  Z flag: result == 0
negative  out  1  N flag: result[N-1]
carry  out  1  C flag
overflow  out  1  V flag

Behaviour:
- Reset:
  - Asynchronous and active-low; takes effect immediately, regardless of clk.
  - result=0, zero=0, negative=0, carry=0, overflow=0, busy=0, done=0.
  - FSM returns to IDLE.
  - Reset during MUL aborts it; no partial result is ever visible.
- FSM states are IDLE and MUL only.
- Issue rules:
  - start is accepted only when busy=0.
  - start while busy=1 is ignored: no queuing, no effect on the operation in flight.
  - a, b and ALUControl are captured at the accepting edge; later changes are irrelevant.
- Single-cycle ops (accepting edge k): result and flags are written at edge k and done=1 for the cycle following edge k. The FSM stays in IDLE.
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b. C = carry out of bit N-1. V = (a[N-1]==b[N-1]) && (result[N-1]!=a[N-1]).
  - 0110 SUB: a + ~b + 1. C = carry out, so C=1 means no borrow. V = (a[N-1]!=b[N-1]) && (result[N-1]!=a[N-1]).
  - 0111 PASS B: b.
  - 0011 LSL: a << b[SHAMT_W-1:0].
  - 0100 LSR: a >> b[SHAMT_W-1:0], logical (zero fill).
  - All other codes: result=0.
  - For every op except ADD/SUB: C=0 and V=0.
- Multi-cycle op 1000 MUL (unsigned shift-add, one multiplier bit per cycle):
  - Accepting edge k: load multiplicand (2N-bit, zero-extended) and multiplier; clear the 2N-bit accumulator and the bit counter; busy=1; go to MUL.
  - Edges k+1 .. k+N: if multiplier LSB=1, add the multiplicand into the accumulator; then shift the multiplicand left by 1 and the multiplier right by 1; increment the counter.
  - Edge k+N: result = low N bits of the product; V = (high N bits != 0); C=0; busy=0; done=1 for one cycle; back to IDLE.
  - busy is high for exactly N cycles; latency is N edges from the accepting edge to the done edge.
  - start on the same edge MUL completes is not accepted, because busy is still 1 at that edge.
- Z and N flags are always derived from the registered result value.
- done is high for exactly one cycle per accepted operation and is never asserted without a prior accepted start.
- result and all flags hold their values between done pulses.
- Back-to-back single-cycle ops (start held high) complete one per cycle, with done continuously high.

Test Plan:
- N=64, ADD, a=64'h7FFF_FFFF_FFFF_FFFF, b=2, start 1 cycle → one cycle after the accepting edge: result=64'h8000_0000_0000_0001, N=1, V=1, C=0, Z=0, done pulses once, busy stays 0.
- N=64, SUB, a=b=64'd27586970463758451 → result=0, Z=1, C=1, V=0. Then AND a=64'd27586970463758451, b=64'd18419157103245793164 → result=0, Z=1, C=0.
- N=64, MUL, a=123456789, b=1000 → busy=1 for exactly 64 cycles, then result=64'd123456789000, V=0, done pulses 64 edges after the accepting edge. MUL a=64'h8000_0000_0000_0000, b=2 → result=0, Z=1, V=1.
- N=64, MUL in flight; at cycle 10 assert start with ADD a=1, b=1 → ignored; final result is the MUL product; exactly one done pulse.
- N=64, drop reset (low) at cycle 20 of a MUL, mid-cycle → busy, done, result and all flags go to 0 immediately (asynchronously); after release, a new ADD 3+4 → result=7 one cycle after its accepting edge.
- N=8 instance:
  - SUB a=8'h80, b=8'hFF → result=8'h81, C=0, V=0, N=1.
  - LSR a=8'h80, b=3 → 8'h10.
  - LSL a=8'h01, b=8'h0A (amount 2) → 8'h04.
  - MUL a=8'h10, b=8'h10 → result=0, V=1, busy for 8 cycles.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add multiply
// Results and NZCV flags are registered and held until the next completion.
module alu_mc #(
  parameter int N       = 64,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow
);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  state_t           state_q, state_d;
  logic [N-1:0]     result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic             is_sub;
  logic [N-1:0]     b_op;
  logic [N:0]       sum_ext;
  logic [N-1:0]     sc_result;
  logic             sc_carry;
  logic             sc_ovf;
  logic [2*N-1:0]   mul_sum;

  // SUB reuses the adder as a + ~b + 1 so carry out means "no borrow"
  assign is_sub  = (ALUControl == OP_SUB);
  assign b_op    = is_sub ? ~b : b;
  assign sum_ext = {1'b0, a} + {1'b0, b_op} + (N+1)'(is_sub);

  always_comb begin
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    case (ALUControl)
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_ADD: begin
        sc_result = sum_ext[N-1:0];
        sc_carry  = sum_ext[N];
        sc_ovf    = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_result = sum_ext[N-1:0];
        sc_carry  = sum_ext[N];
        sc_ovf    = (a[N-1] != b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OP_PASS: sc_result = b;
      OP_LSL:  sc_result = a << b[SHAMT_W-1:0];
      OP_LSR:  sc_result = a >> b[SHAMT_W-1:0];
      default: sc_result = '0;
    endcase
  end

  assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALUControl == OP_MUL) begin
            mcand_d  = {{N{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = sc_result;
            zero_d   = (sc_result == '0);
            neg_d    = sc_result[N-1];
            carry_d  = sc_carry;
            ovf_d    = sc_ovf;
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last multiplier bit: publish the folded product directly
        if (cnt_q == SHAMT_W'(N-1)) begin
          state_d  = S_IDLE;
          result_d = mul_sum[N-1:0];
          zero_d   = (mul_sum[N-1:0] == '0);
          neg_d    = mul_sum[N-1];
          carry_d  = 1'b0;
          ovf_d    = |mul_sum[2*N-1:N];
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy     = (state_q == S_MUL);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule
